// File: rtl/tone_sequencer_pkg.sv
// tone_sequencer_pkg: shared state encoding, scale constants and address-width helper
package tone_sequencer_pkg;
  localparam int SCALE_W = 6;
  localparam logic [SCALE_W-1:0] END_MARKER = 6'd0;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE} state_e;
  function automatic int addr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tone_table.sv
// tone_table: note table RAM with one write port and one registered read port
module tone_table
  import tone_sequencer_pkg::*;
#(
  parameter int NUM_NOTES = 16,
  parameter int DUR_W = 8
) (
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [addr_w(NUM_NOTES)-1:0]  waddr_i,
  input  logic [SCALE_W-1:0]            wscale_i,
  input  logic [DUR_W-1:0]              wdur_i,
  input  logic [addr_w(NUM_NOTES)-1:0]  raddr_i,
  output logic [SCALE_W-1:0]            rscale_o,
  output logic [DUR_W-1:0]              rdur_o
);
  logic [SCALE_W+DUR_W-1:0] mem_q [NUM_NOTES];
  logic [SCALE_W+DUR_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= {wscale_i, wdur_i};
    rdata_q <= mem_q[raddr_i];
  end
  assign {rscale_o, rdur_o} = rdata_q;
endmodule

// File: rtl/tone_sequencer.sv
// tone_sequencer: steps a programmable note table, driving the square-wave generator's scale and enable
module tone_sequencer
  import tone_sequencer_pkg::*;
#(
  parameter int NUM_NOTES = 16,
  parameter int TICK_DIV = 50000,
  parameter int GAP_TICKS = 1,
  parameter int DUR_W = 8
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          loop_en,
  input  logic                          prog_we,
  input  logic [addr_w(NUM_NOTES)-1:0]  prog_addr,
  input  logic [SCALE_W-1:0]            prog_scale,
  input  logic [DUR_W-1:0]              prog_dur,
  output logic [SCALE_W-1:0]            scale_out,
  output logic                          wave_enable,
  output logic                          busy,
  output logic [addr_w(NUM_NOTES)-1:0]  note_index,
  output logic                          done
);
  localparam int AW = addr_w(NUM_NOTES);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam int TW = DUR_W > GW ? DUR_W : GW;
  localparam logic [TW-1:0] GAP_LIM = TW'(GAP_TICKS > 0 ? GAP_TICKS - 1 : 0);
  state_e state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [TW-1:0] tick_q, tick_d, lim_q, lim_d;
  logic busy_q, wave_q, done_q;
  logic [SCALE_W-1:0] rd_scale;
  logic [DUR_W-1:0] rd_dur;
  logic tick_wrap, note_end, last, adv, eos;
  tone_table #(
    .NUM_NOTES(NUM_NOTES),
    .DUR_W(DUR_W)
  ) u_table (
    .clk(sysclk),
    .we_i(prog_we && !busy_q),
    .waddr_i(prog_addr),
    .wscale_i(prog_scale),
    .wdur_i(prog_dur),
    .raddr_i(idx_d),
    .rscale_o(rd_scale),
    .rdur_o(rd_dur)
  );
  assign tick_wrap = pre_q == PW'(TICK_DIV - 1);
  assign note_end = tick_wrap && tick_q == lim_q;
  assign last = idx_q == AW'(NUM_NOTES - 1);
  // The read address is the next index so LOAD always sees the entry it is evaluating.
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    scale_d = scale_q;
    lim_d = lim_q;
    pre_d = tick_wrap ? '0 : pre_q + PW'(1);
    tick_d = tick_wrap ? tick_q + TW'(1) : tick_q;
    adv = 1'b0;
    eos = 1'b0;
    if (stop) state_d = S_IDLE;
    else case (state_q)
      S_IDLE: if (start) begin
        state_d = S_LOAD;
        idx_d = '0;
      end
      S_LOAD: if (rd_scale == END_MARKER) eos = 1'b1;
      else if (rd_dur == '0) adv = 1'b1;
      else begin
        state_d = S_PLAY;
        scale_d = rd_scale;
        lim_d = TW'(rd_dur) - TW'(1);
      end
      S_PLAY: if (note_end) begin
        if (GAP_TICKS > 0) begin
          state_d = S_GAP;
          lim_d = GAP_LIM;
        end else adv = 1'b1;
      end
      S_GAP: adv = note_end;
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      eos = last;
      idx_d = idx_q + AW'(1);
      state_d = S_LOAD;
    end
    if (eos) begin
      idx_d = '0;
      state_d = loop_en ? S_LOAD : S_DONE;
    end
    if (state_d inside {S_IDLE, S_DONE}) begin
      idx_d = '0;
      scale_d = '0;
    end
    // Counters restart on every state entry and idle outside the timed states.
    if (state_d != state_q || !(state_d inside {S_PLAY, S_GAP})) begin
      pre_d = '0;
      tick_d = '0;
    end
  end
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      scale_q <= '0;
      pre_q <= '0;
      tick_q <= '0;
      lim_q <= '0;
      busy_q <= 1'b0;
      wave_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      scale_q <= scale_d;
      pre_q <= pre_d;
      tick_q <= tick_d;
      lim_q <= lim_d;
      busy_q <= state_d != S_IDLE;
      wave_q <= state_d == S_PLAY;
      done_q <= state_d == S_DONE;
    end
  end
  assign scale_out = scale_q;
  assign wave_enable = wave_q;
  assign busy = busy_q;
  assign note_index = idx_q;
  assign done = done_q;
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed and randomized playback checks against a per-cycle trace model
module tb_tone_sequencer;
  localparam int NN = 16;
  localparam int TD = 4;
  localparam int GAP = 1;
  localparam int DW = 8;
  logic sysclk = 1'b0;
  logic reset, start, stop, loop_en, prog_we;
  logic [3:0] prog_addr;
  logic [5:0] prog_scale;
  logic [DW-1:0] prog_dur;
  logic [5:0] scale_out;
  logic wave_enable, busy, done;
  logic [3:0] note_index;
  logic [12:0] obs;
  logic [5:0] tbl_sc [NN];
  int tbl_dur [NN];
  logic [12:0] exp_q [$];
  int total = 0;
  int passed = 0;
  always #5 sysclk = ~sysclk;
  assign obs = {wave_enable, scale_out, note_index, busy, done};
  tone_sequencer #(
    .NUM_NOTES(NN),
    .TICK_DIV(TD),
    .GAP_TICKS(GAP),
    .DUR_W(DW)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .start(start),
    .stop(stop),
    .loop_en(loop_en),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_scale(prog_scale),
    .prog_dur(prog_dur),
    .scale_out(scale_out),
    .wave_enable(wave_enable),
    .busy(busy),
    .note_index(note_index),
    .done(done)
  );
  // Expected observation per cycle, starting with the LOAD cycle right after start is taken.
  task automatic build(input bit lp, input int maxlen);
    int idx;
    logic [5:0] cur;
    bit eos;
    idx = 0;
    cur = '0;
    exp_q.delete();
    while (exp_q.size() < maxlen) begin
      eos = 1'b0;
      exp_q.push_back({1'b0, cur, 4'(idx), 2'b10});
      if (tbl_sc[idx] == 6'd0) eos = 1'b1;
      else begin
        if (tbl_dur[idx] != 0) begin
          cur = tbl_sc[idx];
          repeat (tbl_dur[idx] * TD) exp_q.push_back({1'b1, cur, 4'(idx), 2'b10});
          repeat (GAP * TD) exp_q.push_back({1'b0, cur, 4'(idx), 2'b10});
        end
        idx++;
        if (idx == NN) eos = 1'b1;
      end
      if (eos) begin
        idx = 0;
        if (!lp) begin
          exp_q.push_back({1'b0, 6'd0, 4'd0, 2'b11});
          exp_q.push_back(13'd0);
          return;
        end
      end
    end
  endtask
  task automatic clear_table();
    for (int i = 0; i < NN; i++) begin
      tbl_sc[i] = 6'd0;
      tbl_dur[i] = 0;
    end
  endtask
  task automatic basic_table();
    clear_table();
    tbl_sc[0] = 6'd10;
    tbl_dur[0] = 2;
    tbl_sc[1] = 6'd20;
    tbl_dur[1] = 1;
  endtask
  task automatic program_table();
    for (int i = 0; i < NN; i++) begin
      @(negedge sysclk);
      prog_we = 1'b1;
      prog_addr = 4'(i);
      prog_scale = tbl_sc[i];
      prog_dur = DW'(tbl_dur[i]);
    end
    @(negedge sysclk);
    prog_we = 1'b0;
  endtask
  // Ends on the falling edge where the LOAD cycle is observable.
  task automatic kick();
    @(negedge sysclk);
    start = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    start = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge sysclk);
    total++;
    if (obs !== 13'd0) $display("FAIL reset_hold: got %b, expected %b", obs, 13'd0);
    else passed++;
    reset = 1'b0;
    @(negedge sysclk);
    total++;
    if (obs !== 13'd0) $display("FAIL reset_release: got %b, expected %b", obs, 13'd0);
    else passed++;
    basic_table();
    program_table();
    kick();
    repeat (4) @(negedge sysclk);
    total++;
    if (obs !== {1'b1, 6'd10, 4'd0, 2'b10}) $display("FAIL reset_preplay: got %b, expected %b", obs, {1'b1, 6'd10, 4'd0, 2'b10});
    else passed++;
    reset = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
    total++;
    if (obs !== 13'd0) $display("FAIL reset_midplay: got %b, expected %b", obs, 13'd0);
    else passed++;
  endtask
  task automatic test_basic();
    basic_table();
    program_table();
    build(1'b0, 1000);
    kick();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge sysclk);
      total++;
      if (obs !== exp_q[i]) $display("FAIL basic cyc %0d: got we|scale|idx|busy|done=%b, expected %b", i, obs, exp_q[i]);
      else passed++;
    end
  endtask
  task automatic test_loop();
    basic_table();
    program_table();
    loop_en = 1'b1;
    build(1'b1, 75);
    kick();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge sysclk);
      total++;
      if (obs !== exp_q[i]) $display("FAIL loop cyc %0d: got we|scale|idx|busy|done=%b, expected %b", i, obs, exp_q[i]);
      else passed++;
    end
    stop = 1'b1;
    @(negedge sysclk);
    stop = 1'b0;
    loop_en = 1'b0;
    total++;
    if (obs !== 13'd0) $display("FAIL loop_stop: got %b, expected %b", obs, 13'd0);
    else passed++;
  endtask
  task automatic test_skip();
    clear_table();
    tbl_sc[0] = 6'd10;
    tbl_dur[0] = 1;
    tbl_sc[1] = 6'd33;
    tbl_dur[1] = 0;
    tbl_sc[2] = 6'd40;
    tbl_dur[2] = 1;
    program_table();
    build(1'b0, 1000);
    kick();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge sysclk);
      total++;
      if (obs !== exp_q[i]) $display("FAIL skip cyc %0d: got we|scale|idx|busy|done=%b, expected %b", i, obs, exp_q[i]);
      else passed++;
    end
  endtask
  task automatic test_stop();
    basic_table();
    program_table();
    build(1'b0, 1000);
    kick();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge sysclk);
      total++;
      if (obs !== exp_q[i]) $display("FAIL stop_pre cyc %0d: got %b, expected %b", i, obs, exp_q[i]);
      else passed++;
    end
    stop = 1'b1;
    @(negedge sysclk);
    stop = 1'b0;
    total++;
    if (obs !== 13'd0) $display("FAIL stop_midplay: got %b, expected %b", obs, 13'd0);
    else passed++;
    start = 1'b1;
    stop = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    stop = 1'b0;
    total++;
    if (obs !== 13'd0) $display("FAIL stop_start_idle: got %b, expected %b", obs, 13'd0);
    else passed++;
    kick();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge sysclk);
      total++;
      if (obs !== exp_q[i]) $display("FAIL stop_replay cyc %0d: got %b, expected %b", i, obs, exp_q[i]);
      else passed++;
    end
  endtask
  task automatic test_prog_busy();
    basic_table();
    program_table();
    build(1'b0, 1000);
    kick();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge sysclk);
      total++;
      if (obs !== exp_q[i]) $display("FAIL prog_busy cyc %0d: got %b, expected %b", i, obs, exp_q[i]);
      else passed++;
      prog_we = i == 3;
      prog_addr = 4'd0;
      prog_scale = 6'd50;
      prog_dur = DW'(2);
    end
    kick();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge sysclk);
      total++;
      if (obs !== exp_q[i]) $display("FAIL prog_ignored cyc %0d: got %b, expected %b", i, obs, exp_q[i]);
      else passed++;
    end
    @(negedge sysclk);
    prog_we = 1'b1;
    @(negedge sysclk);
    prog_we = 1'b0;
    tbl_sc[0] = 6'd50;
    build(1'b0, 1000);
    kick();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge sysclk);
      total++;
      if (obs !== exp_q[i]) $display("FAIL prog_idle cyc %0d: got %b, expected %b", i, obs, exp_q[i]);
      else passed++;
    end
  endtask
  task automatic test_all16();
    for (int k = 0; k < NN; k++) begin
      tbl_sc[k] = 6'(k + 1);
      tbl_dur[k] = 1;
    end
    program_table();
    build(1'b0, 1000);
    kick();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge sysclk);
      total++;
      if (obs !== exp_q[i]) $display("FAIL all16 cyc %0d: got %b, expected %b", i, obs, exp_q[i]);
      else passed++;
    end
  endtask
  task automatic test_random();
    bit lp;
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < NN; k++) begin
        tbl_sc[k] = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
        tbl_dur[k] = int'($urandom_range(0, 3));
      end
      lp = 1'($urandom_range(0, 1));
      program_table();
      loop_en = lp;
      build(lp, 120);
      kick();
      for (int i = 0; i < exp_q.size(); i++) begin
        if (i > 0) @(negedge sysclk);
        total++;
        if (obs !== exp_q[i]) $display("FAIL random run %0d cyc %0d: got %b, expected %b", r, i, obs, exp_q[i]);
        else passed++;
      end
      if (lp) begin
        stop = 1'b1;
        @(negedge sysclk);
        stop = 1'b0;
        total++;
        if (obs !== 13'd0) $display("FAIL random_stop run %0d: got %b, expected %b", r, obs, 13'd0);
        else passed++;
      end
      loop_en = 1'b0;
    end
  endtask
  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    loop_en = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_scale = '0;
    prog_dur = '0;
    test_reset();
    test_basic();
    test_loop();
    test_skip();
    test_stop();
    test_prog_busy();
    test_all16();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
